// File: rtl/online_upper_residual_sequencer.sv
// Upper-slice residual and digit selector for the online-arithmetic datapath.
// Keeps the borrow-save upper residual (plus/minus vectors). Each step it absorbs
// carries, borrows and shift-ins from the lower slices. It then picks a signed
// digit from a window at the top of the residual. A start/done sequencer runs an
// online-delay phase followed by NUM_DIGITS digit steps.
module online_upper_residual_sequencer #(
    parameter int UPPER_BITS   = 5,
    parameter int SEL_BITS     = 3,
    parameter int NUM_DIGITS   = 16,
    parameter int ONLINE_DELAY = 2,
    parameter int CNT_W        = 6
) (
    input  logic             clk,
    input  logic             asyn_reset,
    input  logic             start,
    input  logic             clear,
    input  logic             step_valid,
    input  logic [1:0]       cout_one,
    input  logic [1:0]       cout_two,
    input  logic             borrow_in_upper,
    input  logic [1:0]       shift_in,
    output logic             busy,
    output logic [1:0]       p_value,
    output logic             p_valid,
    output logic [CNT_W-1:0] digit_idx,
    output logic             done,
    output logic             overflow
);

    localparam int UB = UPPER_BITS;
    localparam int SB = SEL_BITS;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ONLINE_DELAY + NUM_DIGITS - 1);
    localparam logic [CNT_W:0]   DELAY_END = (CNT_W+1)'(ONLINE_DELAY);
    localparam logic [SB-1:0]    S_MAX     = {1'b0, {(SB-1){1'b1}}};
    localparam logic [SB-1:0]    S_MIN     = {1'b1, {(SB-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [UB-1:0]    res_plus_reg, res_plus_next;
    logic [UB-1:0]    res_minus_reg, res_minus_next;
    logic [CNT_W-1:0] counter_reg, counter_next;
    logic [1:0]       p_value_reg, p_value_next;
    logic             p_valid_reg, p_valid_next;
    logic             done_reg, done_next;
    logic             overflow_reg, overflow_next;
    logic [CNT_W-1:0] digit_idx_reg, digit_idx_next;

    // Step datapath values, all arithmetic modulo 2^UB
    logic [UB-1:0]    v_plus, v_minus, v;
    logic [SB-1:0]    s;
    logic [CNT_W:0]   step_num;
    logic             in_delay;
    logic             s_pos, s_small, ovf_hit, t_bit;
    logic [1:0]       p_sel, p_step;
    logic [UB-1:0]    res_plus_step, res_minus_step;

    // Absorb lower-slice carries, select the digit and form the shifted residual
    always_comb begin
        v_plus   = res_plus_reg + UB'(cout_one[1]) + UB'(cout_two[1]);
        v_minus  = res_minus_reg + UB'(cout_one[0]) + UB'(cout_two[0]);
        v        = v_plus - v_minus - UB'(borrow_in_upper);
        s        = v[UB-1 -: SB];
        // Step number (1-based) up to and including ONLINE_DELAY is still in the delay phase
        step_num = {1'b0, counter_reg} + (CNT_W+1)'(1);
        in_delay = (step_num <= DELAY_END);
        // s >= 1: sign clear and non-zero. s in {0,-1}: all zeros or all ones.
        s_pos    = !s[SB-1] && (s != '0);
        s_small  = (s == '0) || (s == '1);
        p_sel    = s_pos ? 2'b10 : (s_small ? 2'b00 : 2'b01);
        p_step   = in_delay ? 2'b00 : p_sel;
        ovf_hit  = !in_delay && ((s == S_MAX) || (s == S_MIN));
        // Folding the digit into bit UB-2 leaves at most one surviving MSB per vector
        t_bit    = v_plus[UB-2] ^ v_minus[UB-2] ^ p_step[1] ^ p_step[0];
        res_plus_step  = {t_bit & (v_plus[UB-2] ^ p_step[1]),  v_plus[UB-3:0],  shift_in[1]};
        res_minus_step = {t_bit & (v_minus[UB-2] ^ p_step[0]), v_minus[UB-3:0], shift_in[0]};
    end

    // Next-state and register-update decode for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_next     = state_reg;
        res_plus_next  = res_plus_reg;
        res_minus_next = res_minus_reg;
        counter_next   = counter_reg;
        p_value_next   = p_value_reg;
        p_valid_next   = 1'b0;
        done_next      = 1'b0;
        overflow_next  = overflow_reg;
        digit_idx_next = digit_idx_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = RUN;
                    res_plus_next  = '0;
                    res_minus_next = '0;
                    counter_next   = '0;
                    overflow_next  = 1'b0;
                end
            end
            RUN: begin
                if (step_valid) begin
                    res_plus_next  = res_plus_step;
                    res_minus_next = res_minus_step;
                    p_value_next   = p_step;
                    p_valid_next   = 1'b1;
                    digit_idx_next = counter_reg;
                    counter_next   = counter_reg + CNT_W'(1);
                    overflow_next  = overflow_reg | ovf_hit;
                    if (counter_reg == LAST_STEP) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        // Abort overrides everything, including a simultaneous start; overflow survives
        if (clear) begin
            state_next     = IDLE;
            res_plus_next  = '0;
            res_minus_next = '0;
            counter_next   = '0;
            p_valid_next   = 1'b0;
            done_next      = 1'b0;
            overflow_next  = overflow_reg;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Residual, counter and output registers
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            res_plus_reg  <= '0;
            res_minus_reg <= '0;
            counter_reg   <= '0;
            p_value_reg   <= 2'b00;
            p_valid_reg   <= 1'b0;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            digit_idx_reg <= '0;
        end else begin
            res_plus_reg  <= res_plus_next;
            res_minus_reg <= res_minus_next;
            counter_reg   <= counter_next;
            p_value_reg   <= p_value_next;
            p_valid_reg   <= p_valid_next;
            done_reg      <= done_next;
            overflow_reg  <= overflow_next;
            digit_idx_reg <= digit_idx_next;
        end
    end

    assign busy      = (state_reg == RUN);
    assign p_value   = p_value_reg;
    assign p_valid   = p_valid_reg;
    assign digit_idx = digit_idx_reg;
    assign done      = done_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_online_upper_residual_sequencer.sv
// Directed bench for the upper residual sequencer. One instance has no online
// delay (dz) and exposes raw digit selection. The other uses default parameters
// (dd) for delay, sequencing, clear and overflow. Both share the same stimulus.
module tb_online_upper_residual_sequencer;

    logic       clk;
    logic       asyn_reset;
    logic       start;
    logic       clear;
    logic       step_valid;
    logic [1:0] cout_one;
    logic [1:0] cout_two;
    logic       borrow_in_upper;
    logic [1:0] shift_in;

    logic       dz_busy, dz_p_valid, dz_done, dz_overflow;
    logic [1:0] dz_p_value;
    logic [5:0] dz_digit_idx;
    logic       dd_busy, dd_p_valid, dd_done, dd_overflow;
    logic [1:0] dd_p_value;
    logic [5:0] dd_digit_idx;

    int errors = 0;
    int checks = 0;
    int pv_count;
    int done_count;

    online_upper_residual_sequencer #(.ONLINE_DELAY(0)) dz (
        .clk(clk), .asyn_reset(asyn_reset), .start(start), .clear(clear),
        .step_valid(step_valid), .cout_one(cout_one), .cout_two(cout_two),
        .borrow_in_upper(borrow_in_upper), .shift_in(shift_in),
        .busy(dz_busy), .p_value(dz_p_value), .p_valid(dz_p_valid),
        .digit_idx(dz_digit_idx), .done(dz_done), .overflow(dz_overflow)
    );

    online_upper_residual_sequencer dd (
        .clk(clk), .asyn_reset(asyn_reset), .start(start), .clear(clear),
        .step_valid(step_valid), .cout_one(cout_one), .cout_two(cout_two),
        .borrow_in_upper(borrow_in_upper), .shift_in(shift_in),
        .busy(dd_busy), .p_value(dd_p_value), .p_valid(dd_p_valid),
        .digit_idx(dd_digit_idx), .done(dd_done), .overflow(dd_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [1:0] c1, input logic [1:0] c2,
                        input logic b, input logic [1:0] sh);
        cout_one = c1; cout_two = c2; borrow_in_upper = b; shift_in = sh;
        step_valid = 1'b1;
        tick();
        step_valid = 1'b0;
        cout_one = 2'b00; cout_two = 2'b00; borrow_in_upper = 1'b0; shift_in = 2'b00;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        asyn_reset = 1'b1; start = 1'b0; clear = 1'b0; step_valid = 1'b0;
        cout_one = 2'b00; cout_two = 2'b00; borrow_in_upper = 1'b0; shift_in = 2'b00;

        // Reset state
        tick();
        check("rst_busy", dd_busy, 0);
        check("rst_p_value", dd_p_value, 0);
        check("rst_p_valid", dd_p_valid, 0);
        check("rst_done", dd_done, 0);
        check("rst_overflow", dd_overflow, 0);
        check("rst_digit_idx", dd_digit_idx, 0);
        asyn_reset = 1'b0;
        tick();

        // Positive digit, no online delay
        pulse_clear();
        pulse_start();
        check("pos_busy", dz_busy, 1);
        step(2'b10, 2'b10, 1'b0, 2'b10);
        $display("pos step1 p=%b idx=%0d", dz_p_value, dz_digit_idx);
        check("pos_s1_p", dz_p_value, 2'b00);
        check("pos_s1_valid", dz_p_valid, 1);
        check("pos_s1_idx", dz_digit_idx, 0);
        check("pos_s1_res_plus", dz.res_plus_reg, 5'b00101);
        check("pos_s1_res_minus", dz.res_minus_reg, 5'b00000);
        step(2'b00, 2'b00, 1'b0, 2'b00);
        $display("pos step2 p=%b idx=%0d", dz_p_value, dz_digit_idx);
        check("pos_s2_p", dz_p_value, 2'b10);
        check("pos_s2_valid", dz_p_valid, 1);
        check("pos_s2_idx", dz_digit_idx, 1);
        tick();
        check("pos_gap_valid", dz_p_valid, 0);
        check("pos_gap_hold_p", dz_p_value, 2'b10);

        // Negative digit, no online delay
        pulse_clear();
        pulse_start();
        step(2'b01, 2'b01, 1'b0, 2'b01);
        $display("neg step1 p=%b idx=%0d", dz_p_value, dz_digit_idx);
        check("neg_s1_p", dz_p_value, 2'b00);
        check("neg_s1_res_minus", dz.res_minus_reg, 5'b00101);
        check("neg_s1_res_plus", dz.res_plus_reg, 5'b00000);
        step(2'b00, 2'b00, 1'b0, 2'b00);
        $display("neg step2 p=%b idx=%0d", dz_p_value, dz_digit_idx);
        check("neg_s2_p", dz_p_value, 2'b01);
        check("neg_s2_idx", dz_digit_idx, 1);
        check("neg_overflow", dz_overflow, 0);

        // Online delay forces both leading digits to zero
        pulse_clear();
        pulse_start();
        step(2'b10, 2'b10, 1'b0, 2'b10);
        $display("delay step1 p=%b idx=%0d", dd_p_value, dd_digit_idx);
        check("dly_s1_p", dd_p_value, 2'b00);
        check("dly_s1_valid", dd_p_valid, 1);
        check("dly_s1_idx", dd_digit_idx, 0);
        step(2'b00, 2'b00, 1'b0, 2'b00);
        $display("delay step2 p=%b idx=%0d", dd_p_value, dd_digit_idx);
        check("dly_s2_p", dd_p_value, 2'b00);
        check("dly_s2_valid", dd_p_valid, 1);
        check("dly_s2_idx", dd_digit_idx, 1);

        // Full run: 18 steps with 1-3 cycle gaps, stray start mid-run
        pulse_clear();
        pulse_start();
        pv_count = 0;
        done_count = 0;
        for (int i = 0; i < 18; i++) begin
            step_valid = 1'b1;
            tick();
            step_valid = 1'b0;
            if (dd_p_valid) pv_count++;
            if (dd_done) done_count++;
            $display("full step %0d p=%b idx=%0d busy=%0d", i, dd_p_value, dd_digit_idx, dd_busy);
            check("full_idx", dd_digit_idx, i);
            if (i < 17) begin
                check("full_busy", dd_busy, 1);
                for (int g = 0; g < (i % 3) + 1; g++) begin
                    if (i == 5 && g == 0) start = 1'b1;
                    tick();
                    start = 1'b0;
                    if (dd_p_valid) pv_count++;
                    if (dd_done) done_count++;
                end
            end
        end
        check("full_last_valid", dd_p_valid, 1);
        check("full_last_busy", dd_busy, 0);
        check("full_last_done", dd_done, 0);
        tick();
        if (dd_p_valid) pv_count++;
        check("full_done_pulse", dd_done, 1);
        check("full_done_busy", dd_busy, 0);
        tick();
        if (dd_p_valid) pv_count++;
        check("full_done_end", dd_done, 0);
        check("full_idle_busy", dd_busy, 0);
        check("full_pv_count", pv_count, 18);
        check("full_early_done", done_count, 0);

        // Clear mid-run, then start and clear together
        pulse_clear();
        pulse_start();
        for (int i = 0; i < 4; i++) step(2'b10, 2'b10, 1'b0, 2'b10);
        check("clr_pre_busy", dd_busy, 1);
        clear = 1'b1; step_valid = 1'b1;
        tick();
        clear = 1'b0; step_valid = 1'b0;
        $display("clear busy=%0d p_valid=%0d", dd_busy, dd_p_valid);
        check("clr_busy", dd_busy, 0);
        check("clr_p_valid", dd_p_valid, 0);
        check("clr_res_plus", dd.res_plus_reg, 0);
        check("clr_res_minus", dd.res_minus_reg, 0);
        tick();
        check("clr_no_done", dd_done, 0);
        start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        check("clr_start_busy", dd_busy, 0);

        // Asynchronous reset mid-run takes effect without a clock edge
        pulse_start();
        step(2'b10, 2'b10, 1'b0, 2'b10);
        step(2'b00, 2'b00, 1'b0, 2'b00);
        check("ar_pre_p", dz_p_value, 2'b10);
        #2;
        asyn_reset = 1'b1;
        #1;
        $display("async reset p=%b idx=%0d busy=%0d", dz_p_value, dz_digit_idx, dz_busy);
        check("ar_p_value", dz_p_value, 2'b00);
        check("ar_digit_idx", dz_digit_idx, 0);
        check("ar_busy", dz_busy, 0);
        check("ar_res_plus", dz.res_plus_reg, 0);
        #3;
        asyn_reset = 1'b0;
        tick();

        // Overflow: the delay phase doubles the residual up to s=011
        pulse_clear();
        pulse_start();
        check("ovf_start_clear", dd_overflow, 0);
        step(2'b10, 2'b10, 1'b0, 2'b10);
        step(2'b10, 2'b00, 1'b0, 2'b00);
        check("ovf_res_plus", dd.res_plus_reg, 5'b01100);
        check("ovf_pre_flag", dd_overflow, 0);
        step(2'b00, 2'b00, 1'b0, 2'b00);
        $display("ovf step3 p=%b idx=%0d ovf=%0d", dd_p_value, dd_digit_idx, dd_overflow);
        check("ovf_flag", dd_overflow, 1);
        check("ovf_p", dd_p_value, 2'b10);
        check("ovf_idx", dd_digit_idx, 2);
        for (int i = 3; i < 18; i++) step(2'b00, 2'b00, 1'b0, 2'b00);
        check("ovf_at_last", dd_overflow, 1);
        tick();
        check("ovf_done_pulse", dd_done, 1);
        check("ovf_through_done", dd_overflow, 1);
        pulse_start();
        $display("ovf restart ovf=%0d busy=%0d", dd_overflow, dd_busy);
        check("ovf_cleared", dd_overflow, 0);
        check("ovf_restart_busy", dd_busy, 1);
        pulse_clear();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
